// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, field positions, defaults.
package cp0_unit_pkg;

  // Exception codes from the exception unit (6-bit bus, low 5 bits land in Cause.ExcCode)
  localparam logic [5:0] EXC_INT  = 6'd0;
  localparam logic [5:0] EXC_ADEL = 6'd4;
  localparam logic [5:0] EXC_ADES = 6'd5;
  localparam logic [5:0] EXC_ILOP = 6'd10;
  localparam logic [5:0] EXC_OVER = 6'd12;
  localparam logic [5:0] EXC_NONE = 6'h3F;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Field positions
  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] PRID_DEF       = 32'h0000_1024;

  // Processor mode is exactly the SR.EXL bit
  typedef enum logic {MODE_USER = 1'b0, MODE_HANDLER = 1'b1} cp0_mode_e;

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bus: pipeline side is master, CP0 is slave.
interface cp0_unit_if;
  logic [31:0] PCM;
  logic        BDM;
  logic [5:0]  Exception;
  logic [5:0]  HWInt;
  logic        CP0WE;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WD;
  logic        ERETM;
  logic [31:0] CP0RD;
  logic        GeneralFlush;
  logic        EretReq;
  logic [31:0] RedirectPC;
  logic [31:0] EPCOut;

  modport master (
    output PCM, BDM, Exception, HWInt, CP0WE, CP0Addr, CP0WD, ERETM,
    input  CP0RD, GeneralFlush, EretReq, RedirectPC, EPCOut
  );
  modport slave (
    input  PCM, BDM, Exception, HWInt, CP0WE, CP0Addr, CP0WD, ERETM,
    output CP0RD, GeneralFlush, EretReq, RedirectPC, EPCOut
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, exception/interrupt entry, eret return.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] PRID_VALUE = PRID_DEF
) (
  input  logic        clock,
  input  logic        reset,
  cp0_unit_if.slave   bus
);

  cp0_mode_e   r_mode;      // SR.EXL
  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_flush;
  logic        w_eret;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_exl       = (r_mode == MODE_HANDLER);
  assign w_int_req   = (|(bus.HWInt & r_im)) & r_ie & ~w_exl;
  assign w_exc_req   = (bus.Exception != EXC_NONE) & ~w_exl;
  assign w_flush     = w_int_req | w_exc_req;
  assign w_eret      = bus.ERETM & ~w_flush;
  // Delay-slot victims restart at the branch; wraps mod 2^32
  assign w_victim_pc = bus.BDM ? (bus.PCM - 32'd4) : bus.PCM;

  assign w_sr    = {16'd0, r_im, 8'd0, w_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};

  assign bus.GeneralFlush = w_flush;
  assign bus.EretReq      = w_eret;
  assign bus.RedirectPC   = w_flush ? HANDLER_PC : r_epc;
  assign bus.EPCOut       = r_epc;

  // mfc0 read port: plain register view, no bypass of a same-cycle mtc0
  always_comb begin
    bus.CP0RD = 32'd0;
    case (bus.CP0Addr)
      CP0_SR:    bus.CP0RD = w_sr;
      CP0_CAUSE: bus.CP0RD = w_cause;
      CP0_EPC:   bus.CP0RD = r_epc;
      CP0_PRID:  bus.CP0RD = PRID_VALUE;
      default:   bus.CP0RD = 32'd0;
    endcase
  end

  // Register/mode update: flush entry beats mtc0; eret clears EXL after any mtc0 SR write
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode    <= MODE_USER;
      r_im      <= '0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_flush) begin
        r_mode    <= MODE_HANDLER;
        r_bd      <= bus.BDM;
        r_exccode <= w_int_req ? 5'd0 : bus.Exception[4:0];
        r_epc     <= w_victim_pc & 32'hFFFF_FFFC;
      end else begin
        if (bus.CP0WE) begin
          case (bus.CP0Addr)
            CP0_SR: begin
              r_im   <= bus.CP0WD[SR_IM_HI:SR_IM_LO];
              r_ie   <= bus.CP0WD[SR_IE];
              r_mode <= bus.CP0WD[SR_EXL] ? MODE_HANDLER : MODE_USER;
            end
            CP0_EPC: r_epc <= bus.CP0WD & 32'hFFFF_FFFC;
            default: ;
          endcase
        end
        if (w_eret) r_mode <= MODE_USER;
      end
    end
  end

endmodule
